// File: rtl/ifetch_mw_if.sv
// rtl/ifetch_mw_if.sv - fetch-queue head bus between the fetch front-end and decode
//
// Signals:
//   fq_valid  head group valid
//   fq_pc     aligned base PC of the head group
//   fq_data   head group instructions, slot i = fq_data[32i+:32]
//   fq_mask   valid slots of the head group
//   fq_taken  predicted-taken slot of the head group (one-hot or zero)
//   fq_ready  decode accepts the head group this cycle
// Modports: master = fetch side (drives the group), slave = decode side (drives fq_ready).
interface ifetch_mw_if #(
    parameter int FETCH_WIDTH = 2
);
    logic                       fq_valid;
    logic [31:0]                fq_pc;
    logic [FETCH_WIDTH*32-1:0]  fq_data;
    logic [FETCH_WIDTH-1:0]     fq_mask;
    logic [FETCH_WIDTH-1:0]     fq_taken;
    logic                       fq_ready;

    modport master (
        output fq_valid, fq_pc, fq_data, fq_mask, fq_taken,
        input  fq_ready
    );

    modport slave (
        input  fq_valid, fq_pc, fq_data, fq_mask, fq_taken,
        output fq_ready
    );
endinterface

// File: rtl/ifetch_mw.sv
// rtl/ifetch_mw.sv - multi-slot instruction fetch front-end with fetch queue
//
// Fetches one aligned group of FETCH_WIDTH 32-bit slots per I-cache hit, trims the group
// to the slots from the entry offset up to the first predicted-taken slot, and pushes it
// into an FQ_DEPTH-entry queue feeding decode. Redirects seen during a miss are held in a
// small pending FSM and applied on the next hit.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ic_pc              current fetch PC (also the predictor lookup PC)
//   ic_hit, ic_data    I-cache hit and aligned group data for ic_pc
//   bp_taken           predicted-taken vector for the group, bp_target = lowest taken target
//   flush_valid/pc     high-priority redirect
//   redir_valid/pc     low-priority redirect
//   fq                 fetch-queue head bus (master side)
//   stall_cycles       saturating count of cycles with a miss or a full queue
module ifetch_mw #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] PC_RESET    = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                ic_pc,
    input  logic                       ic_hit,
    input  logic [FETCH_WIDTH*32-1:0]  ic_data,
    input  logic [FETCH_WIDTH-1:0]     bp_taken,
    input  logic [31:0]                bp_target,
    input  logic                       flush_valid,
    input  logic [31:0]                flush_pc,
    input  logic                       redir_valid,
    input  logic [31:0]                redir_pc,
    ifetch_mw_if.master                fq,
    output logic [31:0]                stall_cycles
);
    localparam int GROUP_BYTES = FETCH_WIDTH * 4;
    localparam int PW          = $clog2(FQ_DEPTH);

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_LOW,
        PEND_HIGH
    } pend_t;

    pend_t       pend_q, pend_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [31:0] pc_q, pc_d;

    // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
    logic [31:0]               q_pc    [FQ_DEPTH];
    logic [FETCH_WIDTH*32-1:0] q_data  [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0]    q_mask  [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0]    q_taken [FQ_DEPTH];
    logic [PW-1:0]             rd_ptr, wr_ptr;
    logic [PW:0]               count;

    logic                      full, empty, deq, push, clear;
    logic [31:0]               off, base, next_pc;
    logic [FETCH_WIDTH-1:0]    grp_mask, grp_taken;
    logic                      grp_found;

    assign ic_pc = pc_q;
    assign full  = (count == (PW+1)'(FQ_DEPTH));
    assign empty = (count == '0);
    assign deq   = !empty && fq.fq_ready;
    assign clear = flush_valid || redir_valid;

    // A full queue still accepts a group when the head leaves in the same cycle.
    assign push  = ic_hit && !clear && (pend_q == PEND_NONE) && (!full || deq);

    assign off  = (pc_q >> 2) & 32'(FETCH_WIDTH - 1);
    assign base = pc_q & ~32'(GROUP_BYTES - 1);

    // Walk slots from the entry offset; the group ends at the first predicted-taken slot.
    always_comb begin
        grp_mask  = '0;
        grp_taken = '0;
        grp_found = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if ((32'(i) >= off) && !grp_found) begin
                grp_mask[i] = 1'b1;
                if (bp_taken[i]) begin
                    grp_taken[i] = 1'b1;
                    grp_found    = 1'b1;
                end
            end
        end
    end

    assign next_pc = grp_found ? bp_target : base + 32'(GROUP_BYTES);

    // Pending-redirect FSM and PC selection. A hit always consumes the pending redirect;
    // a held flush beats a live flush so the older commit flush is not lost.
    always_comb begin
        pend_d     = pend_q;
        saved_pc_d = saved_pc_q;
        pc_d       = pc_q;
        if (ic_hit) begin
            pend_d = PEND_NONE;
            if (pend_q == PEND_HIGH) begin
                pc_d = saved_pc_q;
            end else if (flush_valid) begin
                pc_d = flush_pc;
            end else if (pend_q == PEND_LOW) begin
                pc_d = saved_pc_q;
            end else if (redir_valid) begin
                pc_d = redir_pc;
            end else if (push) begin
                pc_d = next_pc;
            end
        end else if (flush_valid && (pend_q != PEND_HIGH)) begin
            pend_d     = PEND_HIGH;
            saved_pc_d = flush_pc;
        end else if (redir_valid && (pend_q == PEND_NONE)) begin
            pend_d     = PEND_LOW;
            saved_pc_d = redir_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= PEND_NONE;
            saved_pc_q   <= 32'h0;
            pc_q         <= PC_RESET;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            stall_cycles <= 32'h0;
        end else begin
            pend_q     <= pend_d;
            saved_pc_q <= saved_pc_d;
            pc_q       <= pc_d;
            if ((!ic_hit || full) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (clear) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (deq) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                count <= count + (PW+1)'(push) - (PW+1)'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= base;
            q_data[wr_ptr]  <= ic_data;
            q_mask[wr_ptr]  <= grp_mask;
            q_taken[wr_ptr] <= grp_taken;
        end
    end

    assign fq.fq_valid = !empty;
    assign fq.fq_pc    = empty ? 32'h0 : q_pc[rd_ptr];
    assign fq.fq_data  = empty ? '0    : q_data[rd_ptr];
    assign fq.fq_mask  = empty ? '0    : q_mask[rd_ptr];
    assign fq.fq_taken = empty ? '0    : q_taken[rd_ptr];
endmodule

// File: tb/tb_ifetch_mw.sv
// tb/tb_ifetch_mw.sv - self-checking bench for ifetch_mw
module tb_ifetch_mw;
    localparam int          FW  = 4;
    localparam int          FQD = 4;
    localparam logic [31:0] PCR = 32'h0;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         ic_pc;
    logic                ic_hit;
    logic [FW*32-1:0]    ic_data;
    logic [FW-1:0]       bp_taken;
    logic [31:0]         bp_target;
    logic                flush_valid;
    logic [31:0]         flush_pc;
    logic                redir_valid;
    logic [31:0]         redir_pc;
    logic [31:0]         stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_mw_if #(.FETCH_WIDTH(FW)) fq_if ();

    ifetch_mw #(.FETCH_WIDTH(FW), .FQ_DEPTH(FQD), .PC_RESET(PCR)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_pc        (ic_pc),
        .ic_hit       (ic_hit),
        .ic_data      (ic_data),
        .bp_taken     (bp_taken),
        .bp_target    (bp_target),
        .flush_valid  (flush_valid),
        .flush_pc     (flush_pc),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .fq           (fq_if),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [FW*32-1:0] data;
        logic [FW-1:0]    mask;
        logic [FW-1:0]    taken;
    } grp_t;

    // Reference state: pend 0=none, 1=low, 2=high.
    logic [31:0] m_pc;
    int          m_pend;
    logic [31:0] m_saved;
    logic [31:0] m_stall;
    grp_t        m_q[$];

    task automatic check(input string tag, input logic [FW*32-1:0] obs, input logic [FW*32-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        grp_t        g;
        int          off, first;
        logic [31:0] nxt;
        logic        full, deq, clear, push;
        if (rst) begin
            m_pc = PCR; m_pend = 0; m_saved = 32'h0; m_stall = 32'h0;
            m_q.delete();
            return;
        end
        full  = (m_q.size() == FQD);
        deq   = (m_q.size() > 0) && fq_if.fq_ready;
        clear = flush_valid || redir_valid;
        if ((!ic_hit || full) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        off   = int'((m_pc / 4) % FW);
        first = -1;
        for (int s = off; s < FW; s++) begin
            if (bp_taken[s] && first < 0) first = s;
        end
        g.pc    = m_pc - (m_pc % (FW * 4));
        g.data  = ic_data;
        g.mask  = '0;
        g.taken = '0;
        for (int s = 0; s < FW; s++) begin
            if (s >= off && (first < 0 || s <= first)) g.mask[s] = 1'b1;
        end
        if (first >= 0) g.taken[first] = 1'b1;
        nxt  = (first >= 0) ? bp_target : g.pc + FW * 4;
        push = 1'b0;
        if (ic_hit) begin
            if (m_pend == 2)       m_pc = m_saved;
            else if (flush_valid)  m_pc = flush_pc;
            else if (m_pend == 1)  m_pc = m_saved;
            else if (redir_valid)  m_pc = redir_pc;
            else if (!full || deq) begin push = 1'b1; m_pc = nxt; end
            m_pend = 0;
        end else if (flush_valid && m_pend != 2) begin
            m_pend = 2; m_saved = flush_pc;
        end else if (redir_valid && !flush_valid && m_pend == 0) begin
            m_pend = 1; m_saved = redir_pc;
        end
        if (clear) begin
            m_q.delete();
        end else begin
            if (deq)  void'(m_q.pop_front());
            if (push) m_q.push_back(g);
        end
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("ic_pc", ic_pc, m_pc);
        check("fq_valid", fq_if.fq_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("fq_pc", fq_if.fq_pc, m_q[0].pc);
            check("fq_data", fq_if.fq_data, m_q[0].data);
            check("fq_mask", fq_if.fq_mask, m_q[0].mask);
            check("fq_taken", fq_if.fq_taken, m_q[0].taken);
        end else begin
            check("fq_pc_empty", fq_if.fq_pc, 0);
            check("fq_mask_empty", fq_if.fq_mask, 0);
        end
        check("stall_cycles", stall_cycles, m_stall);
        ic_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle();
        ic_hit = 0; bp_taken = '0; bp_target = 32'h0;
        flush_valid = 0; flush_pc = 32'h0; redir_valid = 0; redir_pc = 32'h0;
        ic_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    logic [31:0] s0;

    initial begin
        rst = 1; idle(); fq_if.fq_ready = 0;
        cycle();
        check("reset_pc", ic_pc, PCR);
        check("reset_fq_valid", fq_if.fq_valid, 0);
        check("reset_stall", stall_cycles, 0);

        // Sequential fetch, no prediction
        rst = 0; ic_hit = 1; fq_if.fq_ready = 1;
        cycle();
        check("seq_pc1", ic_pc, 32'h10);
        check("seq_head0", fq_if.fq_pc, 32'h0);
        check("seq_mask0", fq_if.fq_mask, 4'hF);
        cycle();
        check("seq_pc2", ic_pc, 32'h20);
        check("seq_head1", fq_if.fq_pc, 32'h10);

        // Mid-group entry with a taken slot
        flush_valid = 1; flush_pc = 32'h104;
        cycle();
        check("flush_to_104", ic_pc, 32'h104);
        flush_valid = 0; fq_if.fq_ready = 0;
        bp_taken = 4'b1100; bp_target = 32'h200;
        cycle();
        check("pred_mask", fq_if.fq_mask, 4'b0110);
        check("pred_taken", fq_if.fq_taken, 4'b0100);
        check("pred_base", fq_if.fq_pc, 32'h100);
        check("pred_pc", ic_pc, 32'h200);

        // Redirects held over a miss, flush overrides
        bp_taken = '0; ic_hit = 0; redir_valid = 1; redir_pc = 32'h300;
        cycle();
        redir_valid = 0; flush_valid = 1; flush_pc = 32'h400;
        cycle();
        flush_valid = 0;
        cycle();
        ic_hit = 1;
        cycle();
        check("pend_pc", ic_pc, 32'h400);
        check("pend_no_enq", fq_if.fq_valid, 0);

        // Fill the queue with decode stalled
        s0 = m_stall;
        for (int i = 0; i < 6; i++) cycle();
        check("full_pc_hold", ic_pc, 32'h440);
        check("full_head", fq_if.fq_pc, 32'h400);
        check("full_stall", stall_cycles, s0 + 2);

        // Push and pop in the same cycle while full
        fq_if.fq_ready = 1;
        cycle();
        check("pushpop_valid", fq_if.fq_valid, 1);
        check("pushpop_head", fq_if.fq_pc, 32'h410);
        check("pushpop_pc", ic_pc, 32'h450);
        ic_hit = 0;
        cycle();
        check("drain_head", fq_if.fq_pc, 32'h420);

        // Flush with three groups queued, then reset during a miss with a pending redirect
        fq_if.fq_ready = 0; ic_hit = 1; flush_valid = 1; flush_pc = 32'h800;
        cycle();
        check("flush_clear", fq_if.fq_valid, 0);
        check("flush_pc", ic_pc, 32'h800);
        ic_hit = 0; flush_valid = 0; redir_valid = 1; redir_pc = 32'h900;
        cycle();
        rst = 1; redir_valid = 0;
        cycle();
        check("rst_pc", ic_pc, PCR);
        rst = 0; ic_hit = 1; fq_if.fq_ready = 1;
        cycle();
        check("rst_drop_pend", ic_pc, PCR + 32'h10);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            ic_hit         = ($urandom_range(0, 3) != 0);
            flush_valid    = ($urandom_range(0, 19) == 0);
            flush_pc       = $urandom & 32'hFFFF_FFFC;
            redir_valid    = ($urandom_range(0, 11) == 0);
            redir_pc       = $urandom & 32'hFFFF_FFFC;
            bp_taken       = ($urandom_range(0, 9) < 3) ? FW'($urandom) : '0;
            bp_target      = $urandom & 32'hFFFF_FFFC;
            fq_if.fq_ready = ($urandom_range(0, 4) < 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
